// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - note codes, divisor helper, FSM states and register map for music_seq
package music_pkg;

    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_C4 = 5'd1,  NOTE_D4 = 5'd2,  NOTE_E4 = 5'd3,  NOTE_F4 = 5'd4;
    localparam logic [4:0] NOTE_G4 = 5'd5,  NOTE_A4 = 5'd6,  NOTE_B4 = 5'd7;
    localparam logic [4:0] NOTE_C5 = 5'd8,  NOTE_D5 = 5'd9,  NOTE_E5 = 5'd10, NOTE_F5 = 5'd11;
    localparam logic [4:0] NOTE_G5 = 5'd12, NOTE_A5 = 5'd13, NOTE_B5 = 5'd14;
    localparam logic [4:0] NOTE_C6 = 5'd15, NOTE_D6 = 5'd16, NOTE_E6 = 5'd17, NOTE_F6 = 5'd18;
    localparam logic [4:0] NOTE_G6 = 5'd19, NOTE_A6 = 5'd20, NOTE_B6 = 5'd21;

    localparam int unsigned BASE_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

    localparam int unsigned REG_CTRL  = 0;
    localparam int unsigned REG_LEN   = 1;
    localparam int unsigned REG_TEMPO = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    function automatic logic note_is_rest(input logic [4:0] code);
        return (code == NOTE_REST) || (code > NOTE_B6);
    endfunction

    // Codes above B4 reuse the base table shifted up by whole octaves.
    function automatic logic [31:0] note_div(input logic [4:0] code, input int unsigned clk_hz);
        int unsigned step;
        int unsigned freq;
        if (note_is_rest(code)) return 32'd0;
        step = 32'(code) - 32'd1;
        freq = BASE_HZ[3'(step % 7)] << (step / 7);
        return clk_hz / (2 * freq);
    endfunction

endpackage

// File: rtl/music_tone.sv
// rtl/music_tone.sv - one square-wave tone channel driven by a 5-bit note code
module music_tone
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] note,
    output logic       tone
);

    logic [31:0] div_tab [32];
    logic [31:0] div;
    logic [4:0]  note_q;
    logic [31:0] cnt_q;
    logic        tone_q;

    for (genvar g = 0; g < 32; g++) begin : g_div
        assign div_tab[g] = note_div(5'(g), CLK_HZ);
    end

    assign div = div_tab[note];

    always_ff @(posedge clk) begin
        if (!rst) begin
            note_q <= NOTE_REST;
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            note_q <= note;
            if (note != note_q || div == 32'd0) begin
                cnt_q  <= '0;
                tone_q <= 1'b0;
            end else if (cnt_q == div - 32'd1) begin
                cnt_q  <= '0;
                tone_q <= ~tone_q;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/music_seq.sv
// rtl/music_seq.sv - register window, song table, entry sequencer and channel mixer
module music_seq
    import music_pkg::*;
#(
    parameter int          CHANNELS   = 2,
    parameter int          SONG_DEPTH = 64,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int          ADDR_W     = $clog2(SONG_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic                  direct_en,
    input  logic [5*CHANNELS-1:0] direct_note,
    output logic                  beep,
    output logic                  playing,
    output logic                  done
);

    localparam int IW = ADDR_W - 1;
    localparam int LW = IW + 1;
    localparam int NW = 5 * CHANNELS;
    localparam int EW = NW + 3;

    logic [EW-1:0]       table_q [SONG_DEPTH];
    logic [EW-1:0]       entry_q;
    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [31:0]         tick_q, tick_d;
    logic [2:0]          beat_q, beat_d;
    logic                done_q, done_d;
    logic [LW-1:0]       len_q;
    logic [31:0]         tempo_q, tempo_eff;
    logic                loop_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                beep_q, beep_d;
    logic [IW-1:0]       waddr;
    logic                tbl_sel, reg_wr, reg_rd, ctrl_wr, start, stop, last_entry;
    logic [NW-1:0]       chan_note;
    logic [CHANNELS-1:0] tone;

    assign waddr      = addr[IW-1:0];
    assign tbl_sel    = addr[ADDR_W-1];
    assign reg_wr     = cs & we & ~tbl_sel;
    assign reg_rd     = cs & ~we & ~tbl_sel;
    assign ctrl_wr    = reg_wr && (waddr == IW'(REG_CTRL));
    assign start      = ctrl_wr && wdata[0] && (len_q != '0);
    assign stop       = ctrl_wr && wdata[1];
    assign tempo_eff  = (tempo_q == 32'd0) ? 32'd1 : tempo_q;
    assign last_entry = (LW'(idx_q) + LW'(1)) >= len_q;
    assign playing    = (state_q != ST_IDLE);

    // Table RAM and its synchronous read port stay out of reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (cs && we && tbl_sel) table_q[waddr] <= {wdata[26:24], wdata[NW-1:0]};
        if (state_q == ST_LOAD) entry_q <= table_q[idx_q];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                state_d = ST_PLAY;
                tick_d  = '0;
                beat_d  = '0;
            end
            ST_PLAY: begin
                if (tick_q == tempo_eff - 32'd1) begin
                    tick_d = '0;
                    if (beat_q == entry_q[EW-1:NW]) state_d = ST_GAP;
                    else                            beat_d  = beat_q + 3'd1;
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            ST_GAP: begin
                if (tick_q == GAP_CYCLES - 32'd1) begin
                    tick_d  = '0;
                    state_d = ST_LOAD;
                    if (!last_entry) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        idx_d = '0;
                        if (!loop_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            default: ;
        endcase
        if (start) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            done_d  = 1'b0;
        end
        if (stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (reg_rd) begin
            if (waddr == IW'(REG_CTRL))       rdata_d = {16'd0, 8'(idx_q), 6'd0, loop_q, playing};
            else if (waddr == IW'(REG_LEN))   rdata_d = 32'(len_q);
            else if (waddr == IW'(REG_TEMPO)) rdata_d = tempo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            loop_q  <= 1'b0;
            len_q   <= '0;
            tempo_q <= '0;
            rdata_q <= '0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            beep_q  <= beep_d;
            if (ctrl_wr) loop_q <= wdata[2];
            if (reg_wr && waddr == IW'(REG_LEN))   len_q   <= LW'(wdata % (SONG_DEPTH + 1));
            if (reg_wr && waddr == IW'(REG_TEMPO)) tempo_q <= wdata;
        end
    end

    // Direct mode only replaces what the channels hear; the sequencer keeps its own timing.
    assign chan_note = direct_en ? direct_note : ((state_q == ST_PLAY) ? entry_q[NW-1:0] : '0);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        music_tone #(.CLK_HZ(CLK_HZ)) u_tone (
            .clk  (clk),
            .rst  (rst),
            .note (chan_note[5*c +: 5]),
            .tone (tone[c])
        );
    end

    always_comb begin
        beep_d = 1'b0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (!note_is_rest(chan_note[5*c +: 5])) beep_d = tone[c];
        end
    end

    assign rdata = rdata_q;
    assign beep  = beep_q;
    assign done  = done_q;

endmodule
